// File: rtl/matmul_top.sv
// matmul_top: N x N integer matrix multiplier, Z = X * Y (mod 2**DATA_WIDTH).
// X, Y and Z are row-major word memories. X/Y are loaded through external
// write ports; Z is read back through a registered read port.
// One multiply-accumulate per cycle, N+2 cycles per Z element, plus one
// final cycle before done rises.
// Optional build macro: MATMUL_WR_LOCK_EN -- when defined, external X/Y
// writes are blocked while a multiply is running.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_COMPUTE | walking (i,j,k), accumulating, writing Z elements
// S_DONE    | Z holds the finished product, done high until next start
module matmul_top #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int VECTOR_SIZE = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  done,
   input  logic [ADDR_WIDTH-1:0] x_wr_addr,
   input  logic                  x_wr_en,
   input  logic [DATA_WIDTH-1:0] x_din,
   input  logic [ADDR_WIDTH-1:0] y_wr_addr,
   input  logic                  y_wr_en,
   input  logic [DATA_WIDTH-1:0] y_din,
   input  logic [ADDR_WIDTH-1:0] z_addr,
   output logic [DATA_WIDTH-1:0] z_dout
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = $clog2(VECTOR_SIZE + 2);
   // phase N+1 is the Z write-back slot of each element
   localparam logic [CW-1:0] PH_LAST  = CW'(VECTOR_SIZE + 1);
   localparam logic [CW-1:0] IDX_LAST = CW'(VECTOR_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPUTE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                state_q;
   logic                  done_q;
   logic                  fin_q;
   logic [CW-1:0]         row_q;
   logic [CW-1:0]         col_q;
   logic [CW-1:0]         ph_q;
   logic [DATA_WIDTH-1:0] acc_q;
   logic [1:0]            rsync_q;
   logic                  run_ok;

   logic [DATA_WIDTH-1:0] x_mem [DEPTH];
   logic [DATA_WIDTH-1:0] y_mem [DEPTH];
   logic [DATA_WIDTH-1:0] z_mem [DEPTH];
   logic [DATA_WIDTH-1:0] x_rd_q;
   logic [DATA_WIDTH-1:0] y_rd_q;

   logic [ADDR_WIDTH-1:0] x_rd_addr;
   logic [ADDR_WIDTH-1:0] y_rd_addr;
   logic [ADDR_WIDTH-1:0] z_wr_addr;
   logic                  z_we;
   logic                  x_we;
   logic                  y_we;

   // the phase counter doubles as k for the read issued this cycle; the data
   // arrives one cycle later, so the MAC in phase p uses element k = p-1
   assign x_rd_addr = ADDR_WIDTH'(row_q * VECTOR_SIZE + ph_q);
   assign y_rd_addr = ADDR_WIDTH'(ph_q * VECTOR_SIZE + col_q);
   assign z_wr_addr = ADDR_WIDTH'(row_q * VECTOR_SIZE + col_q);
   assign z_we      = (state_q == S_COMPUTE) && !fin_q && (ph_q == PH_LAST);
   assign done      = done_q;
   assign run_ok    = rsync_q[1];

`ifdef MATMUL_WR_LOCK_EN
   assign x_we = x_wr_en && (state_q != S_COMPUTE);
   assign y_we = y_wr_en && (state_q != S_COMPUTE);
`else
   assign x_we = x_wr_en;
   assign y_we = y_wr_en;
`endif

   // reset release synchroniser: start is only honoured once this fills
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rsync_q <= 2'b00;
      else        rsync_q <= {rsync_q[0], 1'b1};
   end

   // X memory: external write port, internal registered read (old data on collision)
   always_ff @(posedge clock) begin
      if (x_we) x_mem[x_wr_addr] <= x_din;
      x_rd_q <= x_mem[x_rd_addr];
   end

   // Y memory: external write port, internal registered read (old data on collision)
   always_ff @(posedge clock) begin
      if (y_we) y_mem[y_wr_addr] <= y_din;
      y_rd_q <= y_mem[y_rd_addr];
   end

   // Z memory write-back of each finished element
   always_ff @(posedge clock) begin
      if (z_we) z_mem[z_wr_addr] <= acc_q;
   end

   // Z external read port, one-cycle latency in every state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) z_dout <= '0;
      else        z_dout <= z_mem[z_addr];
   end

   // control FSM with counters, accumulator and registered done
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         done_q  <= 1'b0;
         fin_q   <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         ph_q    <= '0;
         acc_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && run_ok) begin
                  state_q <= S_COMPUTE;
                  done_q  <= 1'b0;
                  fin_q   <= 1'b0;
                  row_q   <= '0;
                  col_q   <= '0;
                  ph_q    <= '0;
                  acc_q   <= '0;
               end
            end
            S_COMPUTE: begin
               if (fin_q) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  fin_q   <= 1'b0;
               end else if (ph_q == PH_LAST) begin
                  ph_q  <= '0;
                  acc_q <= '0;
                  if (col_q == IDX_LAST) begin
                     col_q <= '0;
                     if (row_q == IDX_LAST) begin
                        row_q <= '0;
                        fin_q <= 1'b1;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end else begin
                  ph_q <= ph_q + 1'b1;
                  if (ph_q != '0) acc_q <= acc_q + x_rd_q * y_rd_q;
               end
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_top.sv
// Directed bench for matmul_top (default parameters, N = 8, 32-bit data).
module tb_matmul_top;

   localparam int N = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        done;
   logic [5:0]  x_wr_addr, y_wr_addr, z_addr;
   logic        x_wr_en, y_wr_en;
   logic [31:0] x_din, y_din, z_dout;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] xm [64];
   logic [31:0] ym [64];
   logic [31:0] ez [64];

   int   cycles;
   logic done_after;

   matmul_top #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .VECTOR_SIZE(N)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .done      (done),
      .x_wr_addr (x_wr_addr),
      .x_wr_en   (x_wr_en),
      .x_din     (x_din),
      .y_wr_addr (y_wr_addr),
      .y_wr_en   (y_wr_en),
      .y_din     (y_din),
      .z_addr    (z_addr),
      .z_dout    (z_dout)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_mem();
      for (int a = 0; a < 64; a++) begin
         x_wr_addr = 6'(a);
         y_wr_addr = 6'(a);
         x_din     = xm[a];
         y_din     = ym[a];
         x_wr_en   = 1'b1;
         y_wr_en   = 1'b1;
         step();
      end
      x_wr_en = 1'b0;
      y_wr_en = 1'b0;
   endtask

   task automatic model();
      logic [31:0] acc;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            acc = 32'd0;
            for (int k = 0; k < N; k++) acc = acc + xm[i*N+k] * ym[k*N+j];
            ez[i*N+j] = acc;
         end
   endtask

   task automatic check_z(input string tag);
      for (int a = 0; a < 64; a++) begin
         z_addr = 6'(a);
         step();
         check($sformatf("%s z[%0d]", tag, a), z_dout, ez[a]);
      end
   endtask

   // start for one edge, then count edges until done (optionally re-pulse start)
   task automatic run_mul(input int pulse_at, output int cyc, output logic d_after);
      start = 1'b1;
      step();
      start   = 1'b0;
      d_after = done;
      cyc     = 0;
      while (done !== 1'b1 && cyc < 2000) begin
         if (cyc == pulse_at) start = 1'b1;
         step();
         start = 1'b0;
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0;
      x_wr_addr = '0; y_wr_addr = '0; z_addr = '0;
      x_wr_en = 1'b0; y_wr_en = 1'b0; x_din = '0; y_din = '0;
      repeat (3) step();
      check("reset done", {31'd0, done}, 32'd0);
      check("reset z_dout", z_dout, 32'd0);
      reset = 1'b1;
      repeat (3) step();

      // identity X, Y(r,c) = r*8+c
      for (int a = 0; a < 64; a++) begin
         xm[a] = ((a / N) == (a % N)) ? 32'd1 : 32'd0;
         ym[a] = 32'(a);
         ez[a] = 32'(a);
      end
      load_mem();
      run_mul(-1, cycles, done_after);
      check("ident latency", 32'(cycles), 32'd641);
      check("ident done", {31'd0, done}, 32'd1);
      check_z("ident");
      check("done held", {31'd0, done}, 32'd1);

      // one-cycle read latency
      z_addr = 6'd10;
      step();
      check("lat z10", z_dout, 32'd10);
      z_addr = 6'd20;
      #3;
      check("lat before edge", z_dout, 32'd10);
      step();
      check("lat z20", z_dout, 32'd20);

      // all ones: each product is 1, eight terms sum to 8
      for (int a = 0; a < 64; a++) begin
         xm[a] = 32'hFFFF_FFFF;
         ym[a] = 32'hFFFF_FFFF;
         ez[a] = 32'd8;
      end
      load_mem();
      run_mul(-1, cycles, done_after);
      check("ones latency", 32'(cycles), 32'd641);
      check_z("ones");

      // random data against the model
      for (int a = 0; a < 64; a++) begin
         xm[a] = $urandom;
         ym[a] = $urandom;
      end
      model();
      load_mem();
      run_mul(-1, cycles, done_after);
      check("rand latency", 32'(cycles), 32'd641);
      check_z("rand");

      // restart from DONE with a stray start 100 cycles in
      run_mul(100, cycles, done_after);
      check("restart done drop", {31'd0, done_after}, 32'd0);
      check("restart latency", 32'(cycles), 32'd641);
      check_z("rerun");

      // reset abort 300 cycles into a multiply of fresh data
      for (int a = 0; a < 64; a++) begin
         xm[a] = $urandom;
         ym[a] = $urandom;
      end
      model();
      load_mem();
      z_addr = 6'd63;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (300) step();
      reset = 1'b0;
      #1;
      check("abort done", {31'd0, done}, 32'd0);
      check("abort z_dout", z_dout, 32'd0);
      step();
      reset = 1'b1;
      repeat (3) step();
      run_mul(-1, cycles, done_after);
      check("post-abort latency", 32'(cycles), 32'd641);
      check_z("post-abort");

`ifdef MATMUL_WR_LOCK_EN
      // write X[0]=5 mid-multiply must be dropped
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (50) step();
      x_wr_addr = 6'd0;
      x_din     = 32'd5;
      x_wr_en   = 1'b1;
      step();
      x_wr_en = 1'b0;
      cycles = 51;
      while (done !== 1'b1 && cycles < 2000) begin
         step();
         cycles++;
      end
      check("lock latency", 32'(cycles), 32'd641);
      check_z("lock");
      run_mul(-1, cycles, done_after);
      check("lock rerun latency", 32'(cycles), 32'd641);
      check_z("lock x0 kept");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_top.md
MATMUL_TOP -- requirements
Module: matmul_top

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the element width of X, Y and Z.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the word-address width of each matrix memory; 2**ADDR_WIDTH >= VECTOR_SIZE**2.
REQ-003 Parameter VECTOR_SIZE, default 8, SHALL set N, the dimension of the square N x N matrices.
REQ-004 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL be a synchronous request to begin a multiply.
REQ-007 done  out  1  SHALL flag that Z holds the completed product.
REQ-008 x_wr_addr  in  ADDR_WIDTH  SHALL be the X write word address.
REQ-009 x_wr_en  in  1  SHALL write x_din to X[x_wr_addr] at the clock edge.
REQ-010 x_din  in  DATA_WIDTH  SHALL be the X write data.
REQ-011 y_wr_addr, y_wr_en, y_din SHALL match REQ-008..010 for memory Y.
REQ-012 z_addr  in  ADDR_WIDTH  SHALL be the Z read word address.
REQ-013 z_dout  out  DATA_WIDTH  SHALL be the registered read data of Z[z_addr].

Function
REQ-014 Matrices SHALL be stored row-major: element (r,c) at address r*N+c.
REQ-015 The block SHALL compute Z(i,j) = sum over k of X(i,k)*Y(k,j) for all i,j in 0..N-1.
REQ-016 Products and sums SHALL be integer arithmetic truncated to the low DATA_WIDTH bits (modulo 2**DATA_WIDTH).
REQ-017 The FSM SHALL have states IDLE, COMPUTE and DONE.
REQ-018 In IDLE or DONE, start=1 at an edge SHALL enter COMPUTE, clear done, and zero the row, column, k and accumulator counters.
REQ-019 start SHALL be ignored while in COMPUTE.
REQ-020 COMPUTE SHALL perform one multiply-accumulate per cycle, issuing X and Y reads one cycle ahead of use, and spend exactly N+2 cycles per Z element, element order (i,j) row-major.
REQ-021 Each finished element SHALL be written to Z[i*N+j] and the accumulator cleared before the next element.
REQ-022 After the last element, the FSM SHALL enter DONE and assert done; the start edge to done high SHALL be exactly N*N*(N+2)+1 cycles (641 for N=8).
REQ-023 done SHALL remain high in DONE until the next accepted start or reset.
REQ-024 z_dout SHALL update on the edge after z_addr is presented (one-cycle read latency), in every state.
REQ-025 z_dout values read while in COMPUTE are undefined.
REQ-026 External X/Y writes SHALL be accepted in IDLE and DONE; same-cycle write and internal read of one address SHALL return the old data.
REQ-027 Memory contents SHALL persist across multiplies; consecutive starts without reload SHALL reproduce identical Z.

Reset
REQ-028 reset low SHALL immediately force IDLE, done=0, z_dout=0 and all counters and the accumulator to zero.
REQ-029 reset asserted during COMPUTE SHALL abort the multiply; Z contents are then undefined; X/Y contents are not cleared.
REQ-030 Release of reset SHALL be synchronised to clock before the FSM leaves IDLE.

Configuration
REQ-031 With macro MATMUL_WR_LOCK_EN defined, x_wr_en and y_wr_en SHALL be ignored while in COMPUTE.
REQ-032 Without MATMUL_WR_LOCK_EN, X/Y writes during COMPUTE SHALL take effect and the result is undefined.

Verification
REQ-033 X = identity, Y(r,c)=r*8+c, start -> done after 641 cycles; Z(r,c)=r*8+c at all 64 addresses.
REQ-034 All X and Y elements = 0xFFFFFFFF -> every Z element = 0x00000008 (modulo wrap).
REQ-035 Random 32-bit X, Y -> all 64 Z words match a software model mod 2**32, read via z_addr 0..63 with one-cycle latency, zero errors.
REQ-036 start pulsed again 100 cycles into COMPUTE -> ignored, done still at cycle 641; start in DONE -> done drops next cycle and rises 641 cycles later with identical Z.
REQ-037 reset low 300 cycles into COMPUTE -> done=0, z_dout=0 at once; after release and start, correct Z after 641 cycles.
REQ-038 With MATMUL_WR_LOCK_EN, write X[0]=5 during COMPUTE -> Z unchanged from the expected product and X[0] keeps its old value.
